// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a one-entry skid
// buffer and synchronous flush; control bits read zero whenever the stage is empty.
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter bit FLUSH_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;
  logic [DATA_WIDTH-1:0] main_data, skid_data;
  logic                  in_fire, out_fire;
  logic                  load_main_in, load_main_skid, load_skid;

  assign in_fire   = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : {CTRL_WIDTH{1'b0}};
  assign out_data  = main_data;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Flush overrides everything; an item accepted in the flush cycle is dropped
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_next   = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_next     = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (FLUSH_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a scoreboard of accepted items is
// compared against every item the stage hands downstream.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready, in_ready_fd;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_valid, out_valid_fd;
  logic        out_ready;
  logic [7:0]  out_ctrl, out_ctrl_fd;
  logic [31:0] out_data, out_data_fd;
  logic [1:0]  occupancy, occupancy_fd;

  int assert_count = 0;
  int fail_count   = 0;
  logic [39:0] sb_queue[$];

  pipe_stage_reg #(.CTRL_WIDTH(8), .DATA_WIDTH(32), .FLUSH_DATA(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.CTRL_WIDTH(8), .DATA_WIDTH(32), .FLUSH_DATA(1'b1)) dut_fd (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_fd), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_fd), .out_ready(out_ready), .out_ctrl(out_ctrl_fd), .out_data(out_data_fd),
    .occupancy(occupancy_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] ctrl, input logic [31:0] data,
                               input logic ready);
    in_valid  = valid;
    in_ctrl   = ctrl;
    in_data   = data;
    out_ready = ready;
  endtask

  // Scoreboard: consume on out_fire, record on in_fire, discard everything on flush
  always @(posedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (sb_queue.size() == 0) begin
          checkOutput("sb_unexpected_item", out_data, 32'hDEAD_BEEF);
        end else begin
          logic [39:0] exp_item;
          exp_item = sb_queue.pop_front();
          checkOutput("sb_ctrl", {24'd0, out_ctrl}, {24'd0, exp_item[39:32]});
          checkOutput("sb_data", out_data, exp_item[31:0]);
          checkOutput("sb_data_fd", out_data_fd, exp_item[31:0]);
        end
      end
      if (flush)
        sb_queue.delete();
      else if (in_valid && in_ready)
        sb_queue.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0);
    #3 rst = 1'b0;
    #2;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_occupancy", {30'd0, occupancy}, 32'd0);
    #7 rst = 1'b1;
    step();

    // Fill both entries, then reset asynchronously in the middle of a cycle
    applyStimulus(1'b1, 8'h11, 32'hA, 1'b0);
    step();
    applyStimulus(1'b1, 8'h22, 32'hB, 1'b0);
    step();
    checkOutput("fill_occupancy", {30'd0, occupancy}, 32'd2);
    checkOutput("fill_in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    sb_queue.delete();
    checkOutput("midfull_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midfull_rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    checkOutput("midfull_rst_out_data", out_data, 32'd0);
    checkOutput("midfull_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midfull_rst_occupancy", {30'd0, occupancy}, 32'd0);
    #2 rst = 1'b1;
    step();

    // Streaming with one cycle of latency and no backpressure
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i + 8'h30), 32'(i), 1'b1);
      checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      checkOutput("stream_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stream_out_data", out_data, 32'(i));
      checkOutput("stream_occupancy", {30'd0, occupancy}, 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);
    step();
    checkOutput("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure fills the skid entry and holds the third item upstream
    applyStimulus(1'b1, 8'h0A, 32'hA, 1'b0);
    step();
    checkOutput("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 8'h0B, 32'hB, 1'b0);
    step();
    checkOutput("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_occupancy", {30'd0, occupancy}, 32'd2);
    applyStimulus(1'b1, 8'h0C, 32'hC, 1'b0);
    step();
    checkOutput("bp_held_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_held_occupancy", {30'd0, occupancy}, 32'd2);
    checkOutput("bp_head_a", out_data, 32'hA);
    applyStimulus(1'b1, 8'h0C, 32'hC, 1'b1);
    step();
    checkOutput("bp_drain_b", out_data, 32'hB);
    checkOutput("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    checkOutput("bp_drain_c", out_data, 32'hC);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);
    step();
    checkOutput("bp_empty", {30'd0, occupancy}, 32'd0);

    // Flush while FULL with an item offered; it must never surface
    applyStimulus(1'b1, 8'hFF, 32'h5, 1'b0);
    step();
    applyStimulus(1'b1, 8'h0F, 32'h6, 1'b0);
    step();
    applyStimulus(1'b1, 8'h77, 32'h7, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    checkOutput("flush_out_data_keep", out_data, 32'h5);
    checkOutput("flush_occupancy", {30'd0, occupancy}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_fd_out_data", out_data_fd, 32'd0);
    checkOutput("flush_fd_out_valid", {31'd0, out_valid_fd}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("flush_no_reappear", {31'd0, out_valid}, 32'd0);
    end

    // Simultaneous accept and release in BUSY keeps a single entry
    applyStimulus(1'b1, 8'h40, 32'h40, 1'b1);
    step();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 32'(32'h40 + i), 1'b1);
      step();
      checkOutput("busy_occupancy", {30'd0, occupancy}, 32'd1);
      checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("busy_head", out_data, 32'(32'h40 + i));
    end
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);
    step();
    step();
    checkOutput("sb_queue_empty", 32'(sb_queue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with valid/ready handshake, one-entry skid buffer and synchronous flush. It generalises the fixed-field, always-loading stage registers to any control/data width. It adds backpressure (stall) support and bubble semantics in which control bits read zero whenever the stage is empty. It sits between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

## Interface
- `CTRL_WIDTH`, default 8: control bits (mem_read, mem_write, wb_en, status_write, branch, immediate, …); forced to zero on bubble or flush.
- `DATA_WIDTH`, default 32: payload bits (PC, operands, immediates, dest reg, status).
- `FLUSH_DATA`, default 0: 1 = data registers are also cleared to 0 on flush; 0 = data registers keep their value on flush.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of the stage contents.
- `in_valid` in 1: upstream offers an item.
- `in_ready` out 1: stage can accept; registered output.
- `in_ctrl` in CTRL_WIDTH: upstream control bits.
- `in_data` in DATA_WIDTH: upstream payload.
- `out_valid` out 1: stage holds a valid item.
- `out_ready` in 1: downstream accepts.
- `out_ctrl` out CTRL_WIDTH: control bits of the head item; 0 when `out_valid`=0.
- `out_data` out DATA_WIDTH: payload of the head item; holds its last value when `out_valid`=0.
- `occupancy` out 2: number of items held (0, 1 or 2).

## Operation
- Storage: main entry (drives outputs) and skid entry; each holds ctrl and data.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), BUSY (occ 1, main valid), FULL (occ 2, main and skid valid).
- EMPTY: in_fire → main←in, BUSY.
- BUSY:
  - in_fire & out_fire → main←in, stay BUSY.
  - in_fire & !out_fire → skid←in, FULL.
  - !in_fire & out_fire → EMPTY.
  - Neither → hold.
- FULL: out_fire → main←skid, BUSY. in_ready is 0, so no in_fire occurs in FULL.
- in_ready = (state != FULL), registered from the next state.
- out_valid = (state != EMPTY).
- out_ctrl = out_valid ? main.ctrl : 0.
- out_data = main.data.
- Flush has the highest priority:
  - Next state is EMPTY.
  - Main and skid ctrl are cleared to 0.
  - Data is cleared only if FLUSH_DATA=1.
  - Any in_fire in the flush cycle is accepted (handshake completes) and discarded.
  - Any out_fire in the flush cycle still counts downstream; the item is consumed.
- Ordering is strict FIFO; no item is duplicated or dropped except by flush.
- Reset (asynchronous assert, any state including mid-transfer):
  - state EMPTY; all registers 0.
  - out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Reset deassertion is synchronised externally; the first edge after release behaves as EMPTY.

## Timing
- Latency: an item accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: 1 item/cycle sustained while out_ready=1.
- in_ready falls the cycle after the skid entry fills. It rises the cycle after the FULL→BUSY drain, or after a flush.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- out_ctrl/out_data change only on clock edges or on asynchronous reset.

## Test plan
- Reset mid-FULL:
  - Stimulus: fill with ctrl=0x11/data=0xA, then ctrl=0x22/data=0xB; assert rst low asynchronously.
  - Required response: immediately out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Streaming:
  - Stimulus: in_valid=1, out_ready=1 for 8 cycles, data=0x1..0x8.
  - Required response: out_data 0x1..0x8 in order, each one cycle after acceptance; in_ready never drops.
- Backpressure/skid:
  - Stimulus: out_ready=0 while sending 0xA, 0xB, 0xC.
  - Required response: 0xA and 0xB accepted; in_ready=0 from the cycle after 0xB is accepted; 0xC is held upstream; occupancy=2.
  - Stimulus (continued): out_ready=1.
  - Required response: out_data 0xA, 0xB, 0xC in consecutive cycles.
- Flush while FULL, FLUSH_DATA=0:
  - Stimulus: hold ctrl 0xFF/data 0x5, ctrl 0x0F/data 0x6; pulse flush with in_valid=1 presenting data 0x7.
  - Required response: next cycle out_valid=0, out_ctrl=0x00, out_data=0x5, occupancy=0; 0x7 never appears at the output.
- Flush, FLUSH_DATA=1:
  - Stimulus: same sequence as the previous scenario.
  - Required response: out_data=0 after the flush edge.
- Simultaneous in_fire and out_fire in BUSY for 4 cycles:
  - Required response: occupancy stays 1 and the skid entry is never used.
